// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Feeds payload bytes into the RMII transmit stage's payload FIFO. It pads
//   short packets up to pMIN_PAYLOAD with pPAD_BYTE and drops every byte
//   beyond pMAX_PAYLOAD. When the payload is fully loaded it pulses
//   Eth_Pkt_Rdy, then holds off the next packet until Tx_En falls.
//
//   State table
//     state      | meaning
//     IDLE       | ready for the first byte of a packet
//     LOAD       | forwarding payload bytes into the FIFO
//     DROP       | oversize packet; discarding bytes up to S_Last
//     PAD        | writing pad bytes until the minimum length is reached
//     ARM        | one settle cycle, then the Eth_Pkt_Rdy pulse
//     WAIT_START | waiting for the transmit stage to raise Tx_En
//     WAIT_END   | waiting for Tx_En to fall (frame sent)
//
// Ports
//   Clk, Rst        clock, synchronous active-high reset
//   S_Data/S_Valid/S_Last/S_Ready   source byte stream
//   Tx_En           transmit enable from the transmit stage
//   Eth_Byte/Eth_Byte_Valid         FIFO write port (registered)
//   Eth_Pkt_Rdy     one-cycle pulse: payload loaded
//   Pkt_Len         payload bytes written, including pad
//   Busy            high outside IDLE
//   Err_Oversize    sticky oversize flag
module eth_tx_framer #(
  parameter int         pMIN_PAYLOAD = 46,
  parameter int         pMAX_PAYLOAD = 1500,
  parameter logic [7:0] pPAD_BYTE    = 8'h00
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  S_Data,
  input  logic        S_Valid,
  input  logic        S_Last,
  output logic        S_Ready,
  input  logic        Tx_En,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic [10:0] Pkt_Len,
  output logic        Busy,
  output logic        Err_Oversize
);

  localparam logic [10:0] MIN_C = 11'(pMIN_PAYLOAD);
  localparam logic [10:0] MAX_C = 11'(pMAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE, LOAD, DROP, PAD, ARM, WAIT_START, WAIT_END
  } state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt, cnt_nxt, cnt_inc;
  logic        arm_wait, arm_wait_nxt;
  logic        tx_en_d1;
  logic [7:0]  byte_nxt;
  logic        vld_nxt, rdy_nxt, err_nxt;
  logic        accept;

  // S_Ready is gated by Rst so that every output reads 0 while reset is held.
  assign S_Ready = ~Rst & ((state == IDLE) | (state == LOAD) | (state == DROP));
  assign accept  = S_Valid & S_Ready;
  assign cnt_inc = (cnt == MAX_C) ? cnt : cnt + 11'd1;
  assign Pkt_Len = cnt;
  assign Busy    = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    arm_wait_nxt = 1'b0;
    byte_nxt     = Eth_Byte;
    vld_nxt      = 1'b0;
    rdy_nxt      = 1'b0;
    err_nxt      = Err_Oversize;
    unique case (state)
      IDLE: begin
        if (accept) begin
          vld_nxt  = 1'b1;
          byte_nxt = S_Data;
          cnt_nxt  = 11'd1;
          err_nxt  = 1'b0;
          if (S_Last) begin
            state_nxt = (MIN_C <= 11'd1) ? ARM : PAD;
          end else if (MAX_C <= 11'd1) begin
            err_nxt   = 1'b1;
            state_nxt = DROP;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          vld_nxt  = 1'b1;
          byte_nxt = S_Data;
          cnt_nxt  = cnt_inc;
          if (S_Last) begin
            state_nxt = (cnt_inc < MIN_C) ? PAD : ARM;
          end else if (cnt_inc == MAX_C) begin
            err_nxt   = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (accept && S_Last) state_nxt = ARM;
      end
      PAD: begin
        vld_nxt  = 1'b1;
        byte_nxt = pPAD_BYTE;
        cnt_nxt  = cnt_inc;
        if (cnt_inc >= MIN_C) state_nxt = ARM;
      end
      ARM: begin
        // First cycle lets the final FIFO write land; second issues the pulse.
        if (!arm_wait) begin
          arm_wait_nxt = 1'b1;
        end else begin
          rdy_nxt   = 1'b1;
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        if (Tx_En) state_nxt = WAIT_END;
      end
      WAIT_END: begin
        if (tx_en_d1 && !Tx_En) begin
          state_nxt = IDLE;
          cnt_nxt   = 11'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      cnt            <= 11'd0;
      arm_wait       <= 1'b0;
      tx_en_d1       <= 1'b0;
      Eth_Byte       <= 8'h00;
      Eth_Byte_Valid <= 1'b0;
      Eth_Pkt_Rdy    <= 1'b0;
      Err_Oversize   <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      arm_wait       <= arm_wait_nxt;
      tx_en_d1       <= Tx_En;
      Eth_Byte       <= byte_nxt;
      Eth_Byte_Valid <= vld_nxt;
      Eth_Pkt_Rdy    <= rdy_nxt;
      Err_Oversize   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer: randomized packets, scoreboard of expected
// FIFO writes and ready pulses, transmit-stage Tx_En responder.
module tb_eth_tx_framer;

  localparam int MIN_P = 46;
  localparam int MAX_P = 1500;
  localparam int INF   = 32'h7fffffff;
  localparam int TMO   = 300;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  S_Data = 8'h00;
  logic        S_Valid = 1'b0;
  logic        S_Last = 1'b0;
  logic        S_Ready;
  logic        Tx_En = 1'b0;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Rdy;
  logic [10:0] Pkt_Len;
  logic        Busy;
  logic        Err_Oversize;

  eth_tx_framer dut (
    .Clk(Clk), .Rst(Rst), .S_Data(S_Data), .S_Valid(S_Valid), .S_Last(S_Last),
    .S_Ready(S_Ready), .Tx_En(Tx_En), .Eth_Byte(Eth_Byte),
    .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Pkt_Len(Pkt_Len), .Busy(Busy), .Err_Oversize(Err_Oversize)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int cyc; int len; bit err; } wr_t;
  typedef struct { int cyc; int len; bit err; } pr_t;
  wr_t wq[$];
  pr_t pq[$];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int last_acc_cyc = -1;
  int release_cyc  = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    end
  endtask

  // Monitor: FIFO writes, ready pulses and the S_Ready handshake.
  always @(negedge Clk) begin
    if (chk_en) begin
      bit exp_rdy;
      exp_rdy = !Rst && !(cyc > last_acc_cyc && cyc < release_cyc);
      chk(S_Ready == exp_rdy, "s_ready",
          $sformatf("got %0b want %0b", S_Ready, exp_rdy));
      if (Eth_Byte_Valid) begin
        if (wq.size() == 0) begin
          chk(1'b0, "write", $sformatf("unexpected write of %02h", Eth_Byte));
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk(Eth_Byte == w.d && cyc == w.cyc && int'(Pkt_Len) == w.len &&
              Err_Oversize == w.err, "write",
              $sformatf("got byte %02h cyc %0d len %0d err %0b want %02h %0d %0d %0b",
                        Eth_Byte, cyc, Pkt_Len, Err_Oversize, w.d, w.cyc, w.len, w.err));
        end
      end
      if (Eth_Pkt_Rdy) begin
        if (pq.size() == 0) begin
          chk(1'b0, "pkt_rdy", "unexpected Eth_Pkt_Rdy pulse");
        end else begin
          pr_t p;
          p = pq.pop_front();
          chk(cyc == p.cyc && int'(Pkt_Len) == p.len && Err_Oversize == p.err && Busy,
              "pkt_rdy",
              $sformatf("got cyc %0d len %0d err %0b busy %0b want %0d %0d %0b 1",
                        cyc, Pkt_Len, Err_Oversize, Busy, p.cyc, p.len, p.err));
        end
      end
    end
  end

  // Transmit stage model: after each ready pulse, raise Tx_En a little later,
  // hold it for a while, drop it. The framer may accept again one cycle later.
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en && Eth_Pkt_Rdy) begin
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #1 Tx_En = 1'b1;
        repeat ($urandom_range(1, 8)) @(posedge Clk);
        #1 Tx_En = 1'b0;
        release_cyc = cyc + 1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic drive_byte(input logic [7:0] d, input bit last, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    S_Data = d; S_Valid = 1'b1; S_Last = last;
    for (int t = 0; t < TMO && !done; t++) begin
      @(negedge Clk);
      if (S_Ready) begin
        acc = cyc;
        done = 1'b1;
      end
      @(posedge Clk); #1;
    end
    S_Valid = 1'b0; S_Last = 1'b0;
    if (!done) begin
      $display("FAIL accept_timeout: byte %02h never accepted in %0d cycles", d, TMO);
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "stalled");
    end
  endtask

  task automatic check_idle_zero(input string name);
    chk(Eth_Byte_Valid == 1'b0 && Eth_Byte == 8'h00 && Eth_Pkt_Rdy == 1'b0 &&
        Pkt_Len == 11'd0 && Busy == 1'b0 && Err_Oversize == 1'b0, name,
        $sformatf("got vld %0b byte %02h rdy %0b len %0d busy %0b err %0b want all 0",
                  Eth_Byte_Valid, Eth_Byte, Eth_Pkt_Rdy, Pkt_Len, Busy, Err_Oversize));
  endtask

  // gap < 0: random 0..2 idle cycles per byte. rst_at > 0: reset after that many bytes.
  task automatic send_pkt(input int len, input int gap, input bit rnd,
                          input logic [7:0] base, input int rst_at);
    int acc, kept, pads, g;
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        S_Valid = 1'b0; S_Last = 1'($urandom_range(0, 1)); S_Data = 8'($urandom);
        @(posedge Clk); #1;
      end
      d = rnd ? 8'($urandom) : base + 8'(i);
      drive_byte(d, i == len - 1, acc);
      if (i < MAX_P)
        wq.push_back('{d: d, cyc: acc + 1, len: i + 1, err: (len > MAX_P && i == MAX_P - 1)});
      if (rst_at > 0 && i == rst_at - 1) begin
        Rst = 1'b1;
        @(negedge Clk);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check_idle_zero("rst_mid_load");
        chk(wq.size() == 0 && pq.size() == 0, "rst_flush",
            $sformatf("pending writes %0d pulses %0d want 0 0", wq.size(), pq.size()));
        @(posedge Clk); #1;
        return;
      end
      if (i == len - 1) begin
        kept = (len > MAX_P) ? MAX_P : len;
        pads = (kept < MIN_P) ? MIN_P - kept : 0;
        for (int k = 1; k <= pads; k++)
          wq.push_back('{d: 8'h00, cyc: acc + 1 + k, len: kept + k, err: 1'b0});
        pq.push_back('{cyc: acc + 3 + pads, len: kept + pads, err: (len > MAX_P)});
        release_cyc  = INF;
        last_acc_cyc = acc;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    check_idle_zero("reset_outputs");
    chk(S_Ready == 1'b0, "reset_s_ready", $sformatf("got %0b want 0", S_Ready));
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk_en = 1'b1;

    send_pkt(60, 0, 1'b0, 8'h00, 0);
    send_pkt(10, 0, 1'b0, 8'hA0, 0);
    send_pkt(1600, 0, 1'b1, 8'h00, 0);
    send_pkt(1, 0, 1'b1, 8'h00, 0);
    send_pkt(46, 0, 1'b1, 8'h00, 0);
    send_pkt(50, 2, 1'b0, 8'h40, 0);
    send_pkt(1500, 0, 1'b1, 8'h00, 0);
    send_pkt(45, -1, 1'b1, 8'h00, 0);
    send_pkt(40, 0, 1'b1, 8'h00, 20);
    send_pkt(46, 0, 1'b0, 8'h10, 0);
    for (int k = 0; k < 6; k++)
      send_pkt(int'($urandom_range(1, 120)), -1, 1'b1, 8'h00, 0);

    for (int t = 0; t < 500 && (pq.size() != 0 || Tx_En || release_cyc > cyc); t++)
      @(negedge Clk);
    @(negedge Clk);
    chk(wq.size() == 0, "writes_drained", $sformatf("pending %0d want 0", wq.size()));
    chk(pq.size() == 0, "pulses_drained", $sformatf("pending %0d want 0", pq.size()));
    chk(Busy == 1'b0 && Pkt_Len == 11'd0, "final_idle",
        $sformatf("busy %0b len %0d want 0 0", Busy, Pkt_Len));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Upstream feeder for the RMII transmit stage.
- Accepts a byte stream with an end-of-packet marker and writes payload bytes into the transmit stage's payload FIFO (Eth_Byte / Eth_Byte_Valid).
- Pads short payloads to the 46-byte Ethernet minimum and truncates oversize payloads.
- Pulses Eth_Pkt_Rdy once the full payload is loaded, then holds off the next packet until the transmit stage has finished (Tx_En falls).

Parameters:
pMIN_PAYLOAD, 46, minimum payload bytes; shorter packets are padded up to this count
pMAX_PAYLOAD, 1500, maximum payload bytes forwarded; excess bytes are discarded
pPAD_BYTE, 8'h00, value written for pad bytes

Ports:
Clk  input  1  system clock (50 MHz RMII reference clock domain)
Rst  input  1  synchronous active-high reset
S_Data  input  8  source payload byte
S_Valid  input  1  S_Data valid
S_Last  input  1  marks the final byte of a packet; qualified by S_Valid
S_Ready  output  1  framer can accept a byte this cycle
Tx_En  input  1  transmit-enable from the transmit stage, used for frame start/end detect
Eth_Byte  output  8  byte to the transmit payload FIFO
Eth_Byte_Valid  output  1  FIFO write strobe, one byte per cycle
Eth_Pkt_Rdy  output  1  one-cycle pulse: payload fully loaded, start the frame
Pkt_Len  output  11  payload bytes written for the current/last packet, including pad
Busy  output  1  high in every state except IDLE
Err_Oversize  output  1  sticky; set when a packet exceeds pMAX_PAYLOAD; cleared on the next accepted first byte or on Rst

Behaviour:
- Reset: Clk and Rst are the only clock and reset. Reset is synchronous and active-high. All outputs reset to 0, the state goes to IDLE, and the counters clear.
- Rst mid-operation: the block returns to IDLE with no Eth_Pkt_Rdy. The transmit FIFO shares Rst, so partial payloads are flushed.
- Accept: a byte is accepted on a cycle with S_Valid & S_Ready.
- Write latency: an accepted byte appears on Eth_Byte with Eth_Byte_Valid=1 exactly 1 cycle later, through a registered output.
- Write rate: Eth_Byte_Valid is high at most 1 cycle per byte. Byte order is preserved.
- Byte counter: 11 bits, saturating at pMAX_PAYLOAD. Pkt_Len tracks the counter and holds its value after the packet.
- FSM states: IDLE, LOAD, DROP, PAD, ARM, WAIT_START, WAIT_END.
- IDLE:
  - S_Ready=1.
  - The first accepted byte is written, the counter becomes 1, and Err_Oversize clears.
  - If that byte has S_Last=1, go to PAD (or ARM if pMIN_PAYLOAD<=1). Otherwise go to LOAD.
- LOAD:
  - S_Ready=1. Each accepted byte is written and the counter increments.
  - On an accepted byte with S_Last: go to PAD if the new count < pMIN_PAYLOAD, else go to ARM.
  - If the count reaches pMAX_PAYLOAD without S_Last: set Err_Oversize and go to DROP.
- DROP:
  - S_Ready=1. Accepted bytes are discarded with no FIFO write.
  - On an accepted byte with S_Last, go to ARM.
- PAD:
  - S_Ready=0. Writes pPAD_BYTE every cycle and increments the counter until count == pMIN_PAYLOAD, then goes to ARM.
- ARM:
  - Waits 1 cycle so the last FIFO write commits.
  - Eth_Pkt_Rdy=1 for exactly 1 cycle, then go to WAIT_START.
- WAIT_START:
  - S_Ready=0. Wait for Tx_En=1, then go to WAIT_END.
- WAIT_END:
  - S_Ready=0. On a Tx_En 1->0 transition (registered Tx_En_d1=1 & Tx_En=0), go to IDLE and clear the counter.
- S_Valid low mid-packet: the block stays in LOAD indefinitely, with no timeout.
- S_Last outside an accepted handshake is ignored.
- At most one packet is in the FIFO at any time. The FIFO depth (>=pMAX_PAYLOAD) is guaranteed by the transmit stage, so full is never checked here.

Test Plan:
- 60-byte packet 0x00..0x3B, S_Valid continuous -> 60 FIFO writes in order, no pad. Eth_Pkt_Rdy pulses once, 2 cycles after the last write. Pkt_Len=60.
- 10-byte packet 0xA0..0xA9 -> 10 data writes, then 36 writes of 0x00 on consecutive cycles. Pkt_Len=46, one Eth_Pkt_Rdy pulse, S_Ready=0 during PAD.
- 1600-byte packet -> exactly 1500 writes. Err_Oversize=1 when the count hits 1500. The remaining 100 bytes are accepted and dropped. Eth_Pkt_Rdy follows S_Last.
- Second packet presented while Tx_En is high -> S_Ready=0 until 1 cycle after Tx_En falls, then the first byte is accepted. Err_Oversize clears if it was set.
- Gapped S_Valid (1 of every 3 cycles), 50 bytes -> 50 writes, each 1 cycle after its accept, with correct order.
- Rst asserted for 1 cycle in LOAD after 20 bytes -> all outputs 0 and no Eth_Pkt_Rdy. A new 46-byte packet then runs normally.
